// File: rtl/vga_tile_scan.sv
// ============================================================================
// Module   : vga_tile_scan
// Purpose  : 640x480@60 raster timing with tile-coordinate outputs and
//            sync/active delayed to match downstream renderer latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vga_tile_scan #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int TILE_SHIFT   = 4,
  parameter int DRAW_LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [5:0] o_col,
  output logic [5:0] o_row,
  output logic       o_frame_start,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync
);

  localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
  localparam logic [9:0] c_h_last     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0] c_v_last     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0] c_off_screen = 6'h3F;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [5:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic       frame_start_q, frame_start_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       w_h_vis;
  logic       w_v_vis;

  always_comb begin
    h_cnt_d       = h_cnt_q + 10'd1;
    v_cnt_d       = v_cnt_q;
    w_h_vis       = (h_cnt_q < c_h_active);
    w_v_vis       = (v_cnt_q < c_v_active);
    col_d         = c_off_screen;
    row_d         = c_off_screen;
    active_d      = w_h_vis && w_v_vis;
    hsync_d       = !((h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end));
    vsync_d       = !((v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end));
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    if (h_cnt_q == c_h_last) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == c_v_last) ? 10'd0 : v_cnt_q + 10'd1;
    end

    // Blanking on either axis parks both coordinates off the playfield.
    if (w_h_vis && w_v_vis) begin
      col_d = 6'(h_cnt_q >> TILE_SHIFT);
      row_d = 6'(v_cnt_q >> TILE_SHIFT);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      col_q         <= 6'd0;
      row_q         <= 6'd0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign o_col         = col_q;
  assign o_row         = row_q;
  assign o_frame_start = frame_start_q;

  generate
    if (DRAW_LATENCY == 0) begin : g_direct
      assign o_active = active_q;
      assign o_hsync  = hsync_q;
      assign o_vsync  = vsync_q;
    end else begin : g_delay
      logic [DRAW_LATENCY-1:0] act_dly_q;
      logic [DRAW_LATENCY-1:0] hs_dly_q;
      logic [DRAW_LATENCY-1:0] vs_dly_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          act_dly_q <= '0;
          hs_dly_q  <= '1;
          vs_dly_q  <= '1;
        end else begin
          act_dly_q[0] <= active_q;
          hs_dly_q[0]  <= hsync_q;
          vs_dly_q[0]  <= vsync_q;
          for (int i = 1; i < DRAW_LATENCY; i++) begin
            act_dly_q[i] <= act_dly_q[i-1];
            hs_dly_q[i]  <= hs_dly_q[i-1];
            vs_dly_q[i]  <= vs_dly_q[i-1];
          end
        end
      end

      assign o_active = act_dly_q[DRAW_LATENCY-1];
      assign o_hsync  = hs_dly_q[DRAW_LATENCY-1];
      assign o_vsync  = vs_dly_q[DRAW_LATENCY-1];
    end
  endgenerate

endmodule

`default_nettype wire
